// File: rtl/hc00_tester_pkg.sv
// Shared types and helpers for the 74HC00 quad-NAND tester.
// Optional feature macro: HC00_TESTER_STOP_ON_ERR_EN.
package hc00_tester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] PAT_LAST = 8'hFF;
    localparam int         ERR_W    = 9;

    function automatic logic [3:0] nand4(
        input logic [3:0] a,
        input logic [3:0] b
    );
        return ~(a & b);
    endfunction

endpackage

// File: rtl/hc00_sync2.sv
// Two-flop synchronizer, parameterized width, synchronous reset.
// Used to bring the asynchronous gate outputs into the clk domain.
module hc00_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/hc00_tester.sv
// Exhaustive 256-pattern tester for a quad 2-input NAND (74HC00).
// Define HC00_TESTER_STOP_ON_ERR_EN to end a run on the first bad pattern.
module hc00_tester
    import hc00_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:1] a_out,
    output logic [4:1] b_out,
    input  logic [4:1] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [4:1] gate_fail,
    output logic [7:0] fail_pat
);

    localparam logic [7:0]       WAIT_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(256);

    state_e           state_q, state_d;
    logic [7:0]       pat_q, pat_d;
    logic [7:0]       wait_q, wait_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       gate_q, gate_d;
    logic [7:0]       fpat_q, fpat_d;
    logic             pass_q, pass_d;

    logic [3:0] y_sync;
    logic [3:0] mis;
    logic       stop_now;
    logic       last_pat;

    hc00_sync2 #(.W(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (y_in),
        .q_o (y_sync)
    );

    assign mis      = y_sync ^ nand4(pat_q[3:0], pat_q[7:4]);
    assign last_pat = (pat_q == PAT_LAST);

`ifdef HC00_TESTER_STOP_ON_ERR_EN
    assign stop_now = last_pat || (mis != 4'b0);
`else
    assign stop_now = last_pat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (wait_q == 8'd0) state_d = CHECK;
            CHECK:   state_d = stop_now ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        a_out = busy ? pat_q[3:0] : 4'b0;
        b_out = busy ? pat_q[7:4] : 4'b0;
    end

    // Results are frozen outside CHECK so they hold from DONE to next start.
    always_comb begin
        pat_d  = pat_q;
        wait_d = wait_q;
        err_d  = err_q;
        gate_d = gate_q;
        fpat_d = fpat_q;
        pass_d = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d  = 8'd0;
                    wait_d = WAIT_LOAD;
                    err_d  = '0;
                    gate_d = 4'b0;
                    fpat_d = 8'd0;
                    pass_d = 1'b0;
                end
            end
            SETTLE: begin
                if (wait_q != 8'd0) wait_d = wait_q - 8'd1;
            end
            CHECK: begin
                if (mis != 4'b0) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                    gate_d = gate_q | mis;
                    fpat_d = pat_q;
                end
                if (stop_now) begin
                    pass_d = (err_d == '0);
                end else begin
                    pat_d  = pat_q + 8'd1;
                    wait_d = WAIT_LOAD;
                end
            end
            DONE:    pass_d = (err_q == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= 8'd0;
            wait_q <= 8'd0;
            err_q  <= '0;
            gate_q <= 4'b0;
            fpat_q <= 8'd0;
            pass_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            wait_q <= wait_d;
            err_q  <= err_d;
            gate_q <= gate_d;
            fpat_q <= fpat_d;
            pass_q <= pass_d;
        end
    end

    assign pass      = pass_q;
    assign err_count = err_q;
    assign gate_fail = gate_q;
    assign fail_pat  = fpat_q;

endmodule

// File: tb/tb_hc00_tester.sv
// Scoreboard bench for hc00_tester driving an ideal NAND model with
// injectable stuck-at-1 outputs.
module tb_hc00_tester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:1] a_out, b_out, y_in;
    logic       busy, done, pass;
    logic [8:0] err_count;
    logic [4:1] gate_fail;
    logic [7:0] fail_pat;
    logic [4:1] stuck1 = 4'b0;

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    bit bench_done = 0;

    typedef struct {
        int t0;
        int dur;
        int pass;
        int err;
        int gate;
        int fpat;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign y_in = ~(a_out & b_out) | stuck1;

    hc00_tester #(.SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_out     (a_out),
        .b_out     (b_out),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .gate_fail (gate_fail),
        .fail_pat  (fail_pat)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int dur, input int p, input int e,
                       input int g, input int f, input bit poke100);
        exp_t x;
        int n;
        pulse_start(x.t0);
        x.dur  = dur;
        x.pass = p;
        x.err  = e;
        x.gate = g;
        x.fpat = f;
        q.push_back(x);
        if (poke100) begin
            repeat (98) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_a"}, int'(a_out), 0);
        chk({tag, "_b"}, int'(b_out), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_gate"}, int'(gate_fail), 0);
        chk({tag, "_fpat"}, int'(fail_pat), 0);
    endtask

    initial begin
        fork
            begin
                exp_t x;
                while (!bench_done) begin
                    @(negedge clk);
                    if (done) begin
                        if (q.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            x = q.pop_front();
                            chk("latency", cyc - x.t0, x.dur);
                            chk("pass", int'(pass), x.pass);
                            chk("err_count", int'(err_count), x.err);
                            chk("gate_fail", int'(gate_fail), x.gate);
                            chk("fail_pat", int'(fail_pat), x.fpat);
                        end
                    end
                end
            end
            begin
                int t0;
                int n;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk_idle("reset");

                run(1280, 1, 0, 0, 0, 0);

                stuck1 = 4'b0100;
`ifdef HC00_TESTER_STOP_ON_ERR_EN
                run(345, 0, 1, 4'b0100, 8'h44, 0);
`else
                run(1280, 0, 64, 4'b0100, 8'hFF, 0);
`endif

                stuck1 = 4'b0001;
`ifdef HC00_TESTER_STOP_ON_ERR_EN
                run(90, 0, 1, 4'b0001, 8'h11, 0);
`else
                run(1280, 0, 64, 4'b0001, 8'hFF, 0);
`endif

                stuck1 = 4'b0;
                run(1280, 1, 0, 0, 0, 1);

`ifdef HC00_TESTER_STOP_ON_ERR_EN
                stuck1 = 4'b0;
`else
                stuck1 = 4'b0100;
`endif
                pulse_start(t0);
                n = 0;
                while (cyc - t0 < 500 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                chk("midrun_busy", int'(busy), 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_idle("midrst");
                stuck1 = 4'b0;
                repeat (2) @(negedge clk);
                run(1280, 1, 0, 0, 0, 0);

                bench_done = 1;
                $display("End of test - %0d assertions evaluated, %0d failures",
                         checks, fails);
                $finish;
            end
        join
    end

endmodule

// File: doc/hc00_tester.md
HC00_TESTER -- requirements
Module: hc00_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning the number of wait cycles after each new pattern is driven before Y is checked; legal range 3..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a test run.
REQ-005 SHALL have port a_out, output, [4:1]: drives the A inputs of the four NAND gates.
REQ-006 SHALL have port b_out, output, [4:1]: drives the B inputs of the four NAND gates.
REQ-007 SHALL have port y_in, input, [4:1]: the gate Y outputs; these are asynchronous to clk.
REQ-008 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a run.
REQ-010 SHALL have port pass, output, 1 bit: high when the last run had zero errors.
REQ-011 SHALL have port err_count, output, 9 bits: the number of failing patterns in the last run.
REQ-012 SHALL have port gate_fail, output, [4:1]: sticky per-gate failure flags.
REQ-013 SHALL have port fail_pat, output, 8 bits: the most recent failing pattern.

Function
REQ-014 SHALL have FSM states IDLE, SETTLE, CHECK and DONE.
REQ-015 SHALL register y_in through a 2-flop synchronizer before any comparison.
REQ-016 SHALL use an 8-bit pattern counter pat, with a_out = pat[3:0] and b_out = pat[7:4] while busy, and a_out = b_out = 0 in IDLE.
REQ-017 SHALL, on start in IDLE, clear pat, err_count, gate_fail, fail_pat and pass, and enter SETTLE with its wait counter loaded to SETTLE_CYCLES-1.
REQ-018 SHALL, in SETTLE, decrement the wait counter and enter CHECK when it reaches 0.
REQ-019 SHALL, in CHECK, compare the synchronized Y against ~(a_out & b_out) bitwise.
  - On any mismatch: increment err_count by 1 (one count per pattern), OR the mismatch bits into gate_fail, and load fail_pat = pat.
REQ-020 SHALL, in CHECK:
  - if pat == 8'hFF, enter DONE;
  - otherwise increment pat and re-enter SETTLE with the wait counter reloaded.
REQ-021 SHALL, in DONE, pulse done for one cycle, set pass = (err_count == 0), and return to IDLE.
REQ-022 SHALL take exactly 256*(SETTLE_CYCLES+1) cycles per pattern sweep: from the start-sampling edge to the DONE entry edge.
REQ-023 SHALL hold busy high in SETTLE, CHECK and DONE.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL keep pass, err_count, gate_fail and fail_pat stable from DONE until the next accepted start.
REQ-026 SHALL never let err_count wrap; its maximum is 256, which fits in 9 bits.

Reset
REQ-027 SHALL, on rst, move to IDLE from any state, including mid-run, on the next edge.
REQ-028 SHALL reset outputs to: a_out = 0, b_out = 0, busy = 0, done = 0, pass = 0, err_count = 0, gate_fail = 0, fail_pat = 0.
REQ-029 SHALL clear the synchronizer flops and the wait counter on rst.

Configuration
REQ-030 SHALL, with HC00_TESTER_STOP_ON_ERR_EN defined, go from CHECK directly to DONE on the first mismatching pattern.
  - err_count = 1 and fail_pat = that pattern.
REQ-031 SHALL, without HC00_TESTER_STOP_ON_ERR_EN, always sweep all 256 patterns.

Structure
REQ-032 SHALL place the following in package hc00_tester_pkg:
  - the state enum;
  - the constant PAT_LAST = 8'hFF;
  - the error-counter width constant (9);
  - a 4-bit nand4 expected-value function.
REQ-033 SHALL instantiate one sub-module, hc00_sync2: a parameterized-width 2-flop synchronizer with synchronous reset.

Verification
REQ-034 SHALL verify the good-gate case: connect an ideal NAND model with SETTLE_CYCLES=4 and pulse start.
  - done at 1280 cycles after start;
  - pass = 1, err_count = 0, gate_fail = 4'b0000.
REQ-035 SHALL verify a stuck-at-1 fault: force y_in[3] = 1 over a full sweep.
  - err_count = 64, gate_fail = 4'b0100, fail_pat = 8'hFF, pass = 0.
REQ-036 SHALL verify stuck-at-1 with stop-on-error: define HC00_TESTER_STOP_ON_ERR_EN and force y_in[1] = 1.
  - DONE after pattern 8'h11;
  - err_count = 1, fail_pat = 8'h11, gate_fail = 4'b0001.
REQ-037 SHALL verify that start is ignored while busy: pulse start again at cycle 100 of a run.
  - the run is not restarted and done still arrives at 1280 cycles.
REQ-038 SHALL verify reset mid-run: assert rst at cycle 500 for 1 cycle.
  - next cycle: IDLE, a_out = b_out = 0, busy = 0, all results 0;
  - a following start produces a full, correct run.
